// File: rtl/blocpu_program_sequencer.sv
// Program sequencer for blocpu_core: streams host words into instruction memory,
// pulses the core reset, runs the core and reports halt, watchdog timeout or abort.
module blocpu_program_sequencer #(
    parameter int          ADDR_W         = 16,
    parameter int          MEM_DEPTH      = 4096,
    parameter int          RESET_CYCLES   = 4,
    parameter logic [31:0] MAX_RUN_CYCLES = 32'd1000000
) (
    input  logic              in_clk,
    input  logic              in_reset_n,
    input  logic              in_start,
    input  logic              in_abort,
    input  logic [11:0]       in_host_word,
    input  logic              in_host_valid,
    input  logic              in_host_last,
    output logic              out_host_ready,
    output logic [11:0]       out_core_instruction,
    output logic [ADDR_W-1:0] out_core_instruction_address,
    output logic              out_core_instruction_write,
    output logic              out_core_reset,
    output logic              out_core_running,
    input  logic              in_core_running,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_timeout,
    output logic              out_overflow,
    output logic [ADDR_W:0]   out_program_length,
    output logic [31:0]       out_run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_LOAD_SETUP,
        S_LOAD_STROBE,
        S_CORE_RESET,
        S_RUN,
        S_DONE
    } state_t;

    localparam int                RCNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [11:0]         instr_reg, instr_next;
    logic                last_reg, last_next;
    logic [ADDR_W:0]     length_reg, length_next;
    logic [31:0]         run_cycles_reg, run_cycles_next;
    logic                timeout_reg, timeout_next;
    logic                overflow_reg, overflow_next;
    logic [RCNT_W-1:0]   rcnt_reg, rcnt_next;
    logic                running_prev_reg, running_prev_next;

    logic busy;
    logic halt;

    assign busy = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign halt = running_prev_reg && !in_core_running;

    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        instr_next        = instr_reg;
        last_next         = last_reg;
        length_next       = length_reg;
        run_cycles_next   = run_cycles_reg;
        timeout_next      = timeout_reg;
        overflow_next     = overflow_reg;
        rcnt_next         = rcnt_reg;
        // Only tracks the core while in RUN, so it is always 0 on entry.
        running_prev_next = 1'b0;

        if (in_abort && busy) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (in_start && !in_abort) begin
                        addr_next       = '0;
                        length_next     = '0;
                        run_cycles_next = '0;
                        timeout_next    = 1'b0;
                        overflow_next   = 1'b0;
                        last_next       = 1'b0;
                        state_next      = S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (in_host_valid) begin
                        instr_next = in_host_word;
                        last_next  = in_host_last;
                        state_next = S_LOAD_SETUP;
                    end
                end
                S_LOAD_SETUP: begin
                    state_next = S_LOAD_STROBE;
                end
                S_LOAD_STROBE: begin
                    length_next = length_reg + (ADDR_W+1)'(1);
                    if (last_reg) begin
                        rcnt_next  = '0;
                        state_next = S_CORE_RESET;
                    end else if (addr_reg == LAST_ADDR) begin
                        // Memory is full: truncate the program and run what fits.
                        overflow_next = 1'b1;
                        rcnt_next     = '0;
                        state_next    = S_CORE_RESET;
                    end else begin
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = S_LOAD_WAIT;
                    end
                end
                S_CORE_RESET: begin
                    if (rcnt_reg == RCNT_LAST) begin
                        state_next = S_RUN;
                    end else begin
                        rcnt_next = rcnt_reg + RCNT_W'(1);
                    end
                end
                S_RUN: begin
                    running_prev_next = in_core_running;
                    if (halt) begin
                        state_next = S_DONE;
                    end else if ((MAX_RUN_CYCLES != 32'd0) && (run_cycles_reg == MAX_RUN_CYCLES)) begin
                        timeout_next = 1'b1;
                        state_next   = S_DONE;
                    end else if (run_cycles_reg != 32'hFFFF_FFFF) begin
                        run_cycles_next = run_cycles_reg + 32'd1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_reg        <= S_IDLE;
            addr_reg         <= '0;
            instr_reg        <= '0;
            last_reg         <= 1'b0;
            length_reg       <= '0;
            run_cycles_reg   <= '0;
            timeout_reg      <= 1'b0;
            overflow_reg     <= 1'b0;
            rcnt_reg         <= '0;
            running_prev_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            instr_reg        <= instr_next;
            last_reg         <= last_next;
            length_reg       <= length_next;
            run_cycles_reg   <= run_cycles_next;
            timeout_reg      <= timeout_next;
            overflow_reg     <= overflow_next;
            rcnt_reg         <= rcnt_next;
            running_prev_reg <= running_prev_next;
        end
    end

    // Core is held in reset while idle; it is released during loading so the
    // CORE_RESET phase produces a clean pulse of exactly RESET_CYCLES.
    assign out_host_ready               = (state_reg == S_LOAD_WAIT);
    assign out_core_instruction         = instr_reg;
    assign out_core_instruction_address = addr_reg;
    assign out_core_instruction_write   = (state_reg == S_LOAD_STROBE);
    assign out_core_reset               = (state_reg == S_IDLE) || (state_reg == S_CORE_RESET);
    assign out_core_running             = (state_reg == S_RUN);
    assign out_busy                     = busy;
    assign out_done                     = (state_reg == S_DONE);
    assign out_timeout                  = timeout_reg;
    assign out_overflow                 = overflow_reg;
    assign out_program_length           = length_reg;
    assign out_run_cycles               = run_cycles_reg;

endmodule

// File: tb/tb_blocpu_program_sequencer.sv
// Directed bench for blocpu_program_sequencer: session driver plus a per-cycle
// monitor that checks writes, length, run counting and pin rules against a model.
module tb_blocpu_program_sequencer;

    localparam int          ADDR_W  = 16;
    localparam int          DEPTH   = 4;
    localparam int          RST_CYC = 4;
    localparam logic [31:0] MAXRUN  = 32'd20;

    logic              clk = 1'b0;
    logic              in_reset_n;
    logic              in_start;
    logic              in_abort;
    logic [11:0]       in_host_word;
    logic              in_host_valid;
    logic              in_host_last;
    logic              out_host_ready;
    logic [11:0]       out_core_instruction;
    logic [ADDR_W-1:0] out_core_instruction_address;
    logic              out_core_instruction_write;
    logic              out_core_reset;
    logic              out_core_running;
    logic              in_core_running;
    logic              out_busy;
    logic              out_done;
    logic              out_timeout;
    logic              out_overflow;
    logic [ADDR_W:0]   out_program_length;
    logic [31:0]       out_run_cycles;

    always #5 clk = ~clk;

    blocpu_program_sequencer #(
        .ADDR_W         (ADDR_W),
        .MEM_DEPTH      (DEPTH),
        .RESET_CYCLES   (RST_CYC),
        .MAX_RUN_CYCLES (MAXRUN)
    ) dut (
        .in_clk                       (clk),
        .in_reset_n                   (in_reset_n),
        .in_start                     (in_start),
        .in_abort                     (in_abort),
        .in_host_word                 (in_host_word),
        .in_host_valid                (in_host_valid),
        .in_host_last                 (in_host_last),
        .out_host_ready               (out_host_ready),
        .out_core_instruction         (out_core_instruction),
        .out_core_instruction_address (out_core_instruction_address),
        .out_core_instruction_write   (out_core_instruction_write),
        .out_core_reset               (out_core_reset),
        .out_core_running             (out_core_running),
        .in_core_running              (in_core_running),
        .out_busy                     (out_busy),
        .out_done                     (out_done),
        .out_timeout                  (out_timeout),
        .out_overflow                 (out_overflow),
        .out_program_length           (out_program_length),
        .out_run_cycles               (out_run_cycles)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [11:0] words [0:7];
    int          sess_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor state: counts writes and run cycles seen since the current session started.
    int                mon_sess     = 0;
    int                mon_writes   = 0;
    int                mon_runs     = 0;
    int                reset_run    = 0;
    logic              prev_write   = 1'b0;
    logic              prev_running = 1'b0;
    logic              prev_reset   = 1'b1;
    logic [ADDR_W-1:0] prev_addr    = '0;
    logic [11:0]       prev_data    = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (sess_id != mon_sess) begin
                mon_sess   = sess_id;
                mon_writes = 0;
                mon_runs   = 0;
            end
            if (out_busy)
                check("program_length", 32'(out_program_length), 32'(mon_writes));
            if (out_core_instruction_write) begin
                check("write_addr", 32'(out_core_instruction_address), 32'(mon_writes));
                check("write_data", 32'(out_core_instruction), 32'(words[mon_writes]));
                check("setup_cycle_no_write", 32'(prev_write), 32'd0);
                check("setup_addr_stable", 32'(out_core_instruction_address), 32'(prev_addr));
                check("setup_data_stable", 32'(out_core_instruction), 32'(prev_data));
                check("ready_during_write", 32'(out_host_ready), 32'd0);
                mon_writes++;
            end
            if (out_done)
                check("done_pins_busy_run_rst", 32'({out_busy, out_core_running, out_core_reset}), 32'd0);
            if (out_core_running) begin
                check("run_cycles_in_run", out_run_cycles, 32'(mon_runs));
                check("run_pins_busy_rst", 32'({out_busy, out_core_reset}), 32'b10);
                if (!prev_running)
                    check("core_reset_pulse_len", 32'(reset_run), 32'(RST_CYC));
                mon_runs++;
            end else if (out_busy) begin
                check("run_cycles_before_run", out_run_cycles, 32'd0);
            end
            reset_run    = out_core_reset ? reset_run + 1 : 0;
            prev_write   = out_core_instruction_write;
            prev_running = out_core_running;
            prev_reset   = out_core_reset;
            prev_addr    = out_core_instruction_address;
            prev_data    = out_core_instruction;
        end
    end

    // mode: 0 normal, 1 abort on strobe number param, 2 abort on the halt edge,
    // 3 pulse in_reset_n at RUN cycle param.
    task automatic session(input int n, input int halt_at, input int mode, input int param,
                           input int exp_len, input logic exp_ovf, input logic exp_to,
                           input int exp_rc);
        int   sent    = 0;
        int   run_idx = 0;
        int   strobes = 0;
        int   cyc     = 0;
        logic ended   = 1'b0;
        logic xfer, wr, run;
        sess_id++;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        while (!ended && cyc < 400) begin
            in_host_valid   = (sent < n);
            in_host_word    = words[(sent < n) ? sent : 0];
            in_host_last    = (sent == n - 1);
            in_core_running = out_core_running && !(halt_at >= 0 && run_idx >= halt_at);
            in_abort        = (mode == 1 && out_core_instruction_write && strobes == param) ||
                              (mode == 2 && out_core_running && run_idx == halt_at);
            if (mode == 3 && out_core_running && run_idx == param) begin
                ended = 1'b1;
                break;
            end
            xfer = in_host_valid && out_host_ready;
            wr   = out_core_instruction_write;
            run  = out_core_running;
            tick();
            if (xfer) sent++;
            if (wr)   strobes++;
            if (run)  run_idx++;
            if (in_abort || out_done) ended = 1'b1;
            cyc++;
        end
        in_host_valid   = 1'b0;
        in_core_running = 1'b0;
        in_abort        = 1'b0;
        check("session_ended_in_budget", 32'(ended), 32'd1);
        if (mode == 0) begin
            check("done", 32'(out_done), 32'd1);
            check("busy_at_done", 32'(out_busy), 32'd0);
            check("final_length", 32'(out_program_length), 32'(exp_len));
            check("write_count", 32'(mon_writes), 32'(exp_len));
            check("overflow", 32'(out_overflow), 32'(exp_ovf));
            check("timeout", 32'(out_timeout), 32'(exp_to));
            check("final_run_cycles", out_run_cycles, 32'(exp_rc));
            tick();
            check("done_holds", 32'(out_done), 32'd1);
            check("run_cycles_hold", out_run_cycles, 32'(exp_rc));
        end else if (mode == 1 || mode == 2) begin
            check("abort_idle_busy", 32'(out_busy), 32'd0);
            check("abort_done", 32'(out_done), 32'd0);
            check("abort_write", 32'(out_core_instruction_write), 32'd0);
            check("abort_core_reset", 32'(out_core_reset), 32'd1);
            check("abort_running", 32'(out_core_running), 32'd0);
            if (mode == 2)
                check("abort_halt_no_timeout", 32'(out_timeout), 32'd0);
        end else begin
            #2;
            in_reset_n = 1'b0;
            #1;
            check("async_rst_running", 32'(out_core_running), 32'd0);
            check("async_rst_core_reset", 32'(out_core_reset), 32'd1);
            check("async_rst_length", 32'(out_program_length), 32'd0);
            check("async_rst_run_cycles", out_run_cycles, 32'd0);
            @(posedge clk);
            #1;
            in_reset_n = 1'b1;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        in_reset_n      = 1'b0;
        in_start        = 1'b0;
        in_abort        = 1'b0;
        in_host_word    = '0;
        in_host_valid   = 1'b0;
        in_host_last    = 1'b0;
        in_core_running = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = '0;
        #2;
        check("rst_core_reset", 32'(out_core_reset), 32'd1);
        check("rst_ctrl_pins", 32'({out_host_ready, out_core_instruction_write, out_core_running,
                                    out_busy, out_done, out_timeout, out_overflow}), 32'd0);
        check("rst_instr", 32'(out_core_instruction), 32'd0);
        check("rst_addr", 32'(out_core_instruction_address), 32'd0);
        check("rst_length", 32'(out_program_length), 32'd0);
        check("rst_run_cycles", out_run_cycles, 32'd0);
        @(posedge clk);
        #1;
        in_reset_n = 1'b1;
        tick();
        tick();

        // Two-word program, core halts 10 cycles into RUN.
        words[0] = 12'h800; words[1] = 12'h940;
        session(2, 10, 0, 0, 2, 1'b0, 1'b0, 10);
        $display("[TB] session halt: length=%0d run_cycles=%0d", out_program_length, out_run_cycles);

        // Core never halts: watchdog ends the run at 20 cycles.
        words[0] = 12'h123; words[1] = 12'h456; words[2] = 12'h789;
        session(3, -1, 0, 0, 3, 1'b0, 1'b1, 20);
        $display("[TB] session timeout: timeout=%0d run_cycles=%0d", out_timeout, out_run_cycles);

        // Six words into a four-word memory: truncated, then run.
        for (int i = 0; i < 6; i++) words[i] = 12'(12'hA10 + i * 7);
        session(6, 3, 0, 0, 4, 1'b1, 1'b0, 3);
        $display("[TB] session overflow: overflow=%0d length=%0d", out_overflow, out_program_length);

        // Abort during the strobe of the third word.
        for (int i = 0; i < 5; i++) words[i] = 12'(12'h3C0 ^ (i * 12'h011));
        session(5, 8, 1, 2, 0, 1'b0, 1'b0, 0);
        $display("[TB] session abort-on-strobe: busy=%0d reset=%0d", out_busy, out_core_reset);

        // Abort in the same cycle as the halt edge.
        words[0] = 12'h5A5;
        session(1, 6, 2, 0, 0, 1'b0, 1'b0, 0);
        $display("[TB] session abort-on-halt: done=%0d timeout=%0d", out_done, out_timeout);

        // Asynchronous reset pulse during RUN, then a fresh session from address 0.
        words[0] = 12'h111; words[1] = 12'h222;
        session(2, -1, 3, 5, 0, 1'b0, 1'b0, 0);
        $display("[TB] session reset-mid-run: core_reset=%0d", out_core_reset);

        words[0] = 12'hFED; words[1] = 12'h0C3; words[2] = 12'h7E1;
        session(3, 4, 0, 0, 3, 1'b0, 1'b0, 4);
        $display("[TB] session reload: length=%0d run_cycles=%0d", out_program_length, out_run_cycles);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
